// File: rtl/ntt_addr_gen_r2.sv
`default_nettype none
// ============================================================================
// Module   : ntt_addr_gen_r2
// Purpose  : Radix-2 NTT butterfly address generator with a parity bank map.
//            Define NTT_ADDR_GEN_TW_EN to add the tw_addr twiddle output.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_addr_gen_r2 #(
    parameter int ADDR_WIDTH  = 9,
    parameter int STAGE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    output logic [ADDR_WIDTH-1:0]  b0,
    output logic [ADDR_WIDTH-1:0]  b1,
    output logic                   sel_a_0,
    output logic                   sel_a_1,
    output logic [STAGE_WIDTH-1:0] stage_o,
    output logic                   valid_o,
    output logic                   busy,
`ifdef NTT_ADDR_GEN_TW_EN
    output logic [ADDR_WIDTH:0]    tw_addr,
`endif
    output logic                   done
);

    localparam logic [STAGE_WIDTH-1:0] c_LAST_S   = STAGE_WIDTH'(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]  c_ONES     = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0]  c_B1_BIT   = ADDR_WIDTH'(1) << (ADDR_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [STAGE_WIDTH-1:0]    r_s;
    logic [ADDR_WIDTH-1:0]     r_j;
    logic [ADDR_WIDTH-1:0]     r_b0;
    logic [ADDR_WIDTH-1:0]     r_b1;
    logic                      r_sel0;
    logic [STAGE_WIDTH-1:0]    r_stage;
    logic                      r_valid;
    logic                      r_done;

    logic [ADDR_WIDTH-1:0]     w_mask;
    logic [ADDR_WIDTH:0]       w_i0;
    logic [ADDR_WIDTH-1:0]     w_b1;
    logic                      w_par;
    logic                      w_issue;
    logic                      w_last_j;
    logic                      w_last_s;

    // Low p bits of j stay put; the rest shift up one to open a zero at bit p.
    assign w_mask   = c_ONES >> r_s;
    assign w_i0     = {(r_j & ~w_mask), 1'b0} | {1'b0, (r_j & w_mask)};
    assign w_b1     = w_i0[ADDR_WIDTH:1] | (c_B1_BIT >> r_s);
    assign w_par    = ^w_i0;
    assign w_issue  = (r_state == S_RUN) && !stall;
    assign w_last_j = &r_j;
    assign w_last_s = (r_s == c_LAST_S);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_issue && w_last_j && w_last_s) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= '0;
            r_j <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_s <= '0;
            r_j <= '0;
        end else if (w_issue) begin
            r_j <= r_j + 1'b1;
            if (w_last_j) begin
                r_s <= w_last_s ? '0 : r_s + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b0    <= '0;
            r_b1    <= '0;
            r_sel0  <= 1'b0;
            r_stage <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_issue;
            r_done  <= (r_state == S_DONE);
            if (w_issue) begin
                r_b0    <= w_i0[ADDR_WIDTH:1];
                r_b1    <= w_b1;
                r_sel0  <= w_par;
                r_stage <= r_s;
            end
        end
    end

`ifdef NTT_ADDR_GEN_TW_EN
    logic [ADDR_WIDTH:0]      r_tw;
    logic [STAGE_WIDTH-1:0]   w_p;

    assign w_p = c_LAST_S - r_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tw <= '0;
        end else if (w_issue) begin
            r_tw <= ({{ADDR_WIDTH{1'b0}}, 1'b1} << r_s) + ({1'b0, r_j} >> w_p);
        end
    end

    assign tw_addr = r_tw;
`endif

    // Operands differ in exactly one index bit, so their bank parities differ.
    assign b0      = r_b0;
    assign b1      = r_b1;
    assign sel_a_0 = r_sel0;
    assign sel_a_1 = ~r_sel0 & (r_valid | r_sel0 | (r_state != S_IDLE) | r_done | (r_b0 != '0) | (r_b1 != '0) | (r_stage != '0));
    assign stage_o = r_stage;
    assign valid_o = r_valid;
    assign busy    = (r_state != S_IDLE) | r_done;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: doc/ntt_addr_gen_r2.md
# ntt_addr_gen_r2

Radix-2 NTT address generator that feeds the bank-input address crossbar. Walks every butterfly of every stage and, each cycle, issues the two coefficient bank addresses plus crossbar selects so that the two operands always land in different banks. Uses a conflict-free parity bank map: bank = XOR of index bits, in-bank address = index >> 1. Also reports stage number, and optionally a twiddle address, to the butterfly datapath.

## Interface
- `addr_width`, default 9: bank address width.
  - N = 2^(addr_width+1) coefficients over 2 banks.
  - L = addr_width+1 stages.
  - 2^addr_width butterflies per stage.
- `stage_width`, default 4: stage counter width; must satisfy 2^stage_width > addr_width.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a full transform; sampled only in IDLE.
- `stall` in 1: downstream hold; when high, no issue and counters freeze.
- `b0` out addr_width: in-bank address of operand index i0.
- `b1` out addr_width: in-bank address of operand index i1.
- `sel_a_0` out 1: bank-0 select (0 → b0, 1 → b1).
- `sel_a_1` out 1: bank-1 select (0 → b0, 1 → b1).
- `stage_o` out stage_width: stage of the current issue.
- `valid_o` out 1: outputs carry a fresh butterfly this cycle.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse after the final issue.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`; clears s=0, j=0.
  - RUN → DONE on issuing s=L-1, j=2^addr_width-1.
  - DONE → IDLE unconditionally after one cycle.
- Index formation for stage s and butterfly j (addr_width bits), with p = L-1-s:
  - i0 = j with a 0 inserted at bit p (L bits).
  - i1 = i0 | (1<<p).
- Bank addresses: b0 = i0[L-1:1], b1 = i1[L-1:1].
- Selects: par = XOR-reduce(i0); sel_a_0 = par, sel_a_1 = ~par.
  - i0 and i1 differ in one bit, so their banks always differ.
- Issue rule: in RUN with `stall`=0, register outputs for (s,j), set valid_o=1, then advance.
  - j increments; on j wrap to 0, s increments.
- Stall: with `stall`=1 in RUN, valid_o=0; b0/b1/selects/stage_o hold their last values; s and j frozen.
- Reset values: all outputs 0, state IDLE, s=0, j=0.
- `start` in RUN or DONE is ignored. `start` coincident with `rst` is ignored.
- `rst` mid-transform aborts: next cycle IDLE, all outputs 0; no done pulse.

## Timing
- Latency: `start` sampled at edge k → first valid_o high in cycle k+1.
- Without stalls:
  - valid_o high for exactly L·2^addr_width consecutive cycles.
  - done high in the cycle after the last valid_o; busy falls with done.
- Each cycle with stall=1 delays all subsequent issues and done by one cycle.
- `stall` during DONE has no effect.
- A new `start` is accepted no earlier than the cycle after done, i.e. in IDLE.

## Configuration
- `NTT_ADDR_GEN_TW_EN` defined: adds output `tw_addr`, width addr_width+1, registered alongside b0/b1 with the same valid/hold rules.
  - tw_addr = 2^s + (j >> p): bit-reversed twiddle ROM index.
  - Reset value 0.
- Not defined: port and logic absent; all other behaviour identical.

## Test plan
All scenarios use addr_width=2: N=8, L=3, 4 butterflies/stage.
- Reset then idle, no start → all outputs 0, busy=0, for 20 cycles.
- Start pulse, stall=0 →
  - 12 consecutive valid cycles, then done 1 cycle, then busy=0.
  - 1st issue: b0=0, b1=2, sel_a_0=0, sel_a_1=1, stage_o=0.
  - 4th issue: b0=1, b1=3.
- Stage-2 check → issue j=1: i0=2, i1=3, b0=1, b1=1, sel_a_0=1, sel_a_1=0; every issue has sel_a_0≠sel_a_1.
- Stall high for 3 cycles at issue 5 →
  - outputs hold, valid_o=0 during stall.
  - Issue sequence unchanged; done 3 cycles later than unstalled run.
- rst at issue 7 → next cycle outputs 0, IDLE, no done; subsequent start gives full 12-issue run from s=0, j=0.
- With NTT_ADDR_GEN_TW_EN → tw_addr = 1 for all stage-0 issues; stage-2 j=3 gives tw_addr=7.
